// File: rtl/spi_master_mc.sv
// rtl/spi_master_mc.sv - full-duplex SPI master, any CPOL/CPHA, bit order and chip-select count
module spi_master_mc #(
  parameter int p_data_width = 8,
  parameter int p_clk_div    = 4,
  parameter int p_cs_num     = 2,
  parameter int p_cs_polar   = 1,
  parameter int p_cpol       = 0,
  parameter int p_cpha       = 0,
  parameter int p_lsb_first  = 0,
  localparam int l_csw       = (p_cs_num > 1) ? $clog2(p_cs_num) : 1
) (
  input  logic                    clk,
  input  logic                    a_rst,
  input  logic                    valid,
  input  logic [p_data_width-1:0] data,
  input  logic [l_csw-1:0]        cs_sel,
  output logic                    ready,
  output logic [p_data_width-1:0] rx_data,
  output logic                    rx_valid,
  output logic                    cs_err,
  output logic                    sck,
  output logic [p_cs_num-1:0]     cs_n,
  output logic                    mosi,
  input  logic                    miso
);

  localparam int l_half  = p_clk_div / 2;
  localparam int l_cnt_w = (l_half > 1) ? $clog2(l_half) : 1;
  localparam int l_hp_w  = $clog2(2 * p_data_width);
  localparam logic l_cpol = (p_cpol != 0);
  localparam logic [p_cs_num-1:0] l_cs_off = (p_cs_polar != 0) ? {p_cs_num{1'b1}} : {p_cs_num{1'b0}};
  localparam logic [p_cs_num-1:0] l_cs_one = p_cs_num'(1);
  localparam logic [l_hp_w-1:0]   l_hp_last = l_hp_w'(2 * p_data_width - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD} state_t;

  state_t                  state, state_nxt;
  logic [l_cnt_w-1:0]      cnt;
  logic [l_hp_w-1:0]       hp, hp_nxt;
  logic [p_data_width-1:0] tx_sr, rx_sr;
  logic                    last_cnt, last_hp, lead;
  logic                    accept, finish, tog, do_sample, do_drive;
  logic                    sel_ok;

  function automatic logic first_bit(input logic [p_data_width-1:0] v);
    return (p_lsb_first != 0) ? v[0] : v[p_data_width-1];
  endfunction

  function automatic logic [p_data_width-1:0] shift_out(input logic [p_data_width-1:0] v);
    return (p_lsb_first != 0) ? (v >> 1) : (v << 1);
  endfunction

  function automatic logic [p_data_width-1:0] shift_in(input logic [p_data_width-1:0] v, input logic b);
    return (p_lsb_first != 0) ? {b, v[p_data_width-1:1]} : {v[p_data_width-2:0], b};
  endfunction

  assign sel_ok = (int'(cs_sel) < p_cs_num);

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = (state == S_IDLE);
    accept    = 1'b0;
    finish    = 1'b0;
    tog       = 1'b0;
    last_cnt  = (cnt == l_cnt_w'(l_half - 1));
    last_hp   = (hp == l_hp_last);
    hp_nxt    = (state == S_SETUP) ? '0 : hp + 1'b1;
    case (state)
      S_IDLE:  if (valid) begin accept = 1'b1; state_nxt = S_SETUP; end
      S_SETUP: if (last_cnt) begin tog = 1'b1; state_nxt = S_SHIFT; end
      S_SHIFT: if (last_cnt) begin
                 if (last_hp) state_nxt = S_HOLD;
                 else         tog = 1'b1;
               end
      S_HOLD:  if (last_cnt) begin finish = 1'b1; state_nxt = S_IDLE; end
      default: state_nxt = S_IDLE;
    endcase
    // Even half-period index = leading sck edge.
    lead      = ~hp_nxt[0];
    do_sample = tog && (lead != (p_cpha != 0));
    do_drive  = tog && ((p_cpha != 0) ? lead : (!lead && hp_nxt != l_hp_last));
  end

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      cnt      <= '0;
      hp       <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      sck      <= l_cpol;
      cs_n     <= l_cs_off;
      mosi     <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      cs_err   <= 1'b0;
    end else begin
      rx_valid <= finish;
      cs_err   <= accept && !sel_ok;
      if (state == S_IDLE || last_cnt) cnt <= '0;
      else                             cnt <= cnt + 1'b1;
      if (tog) begin
        hp  <= hp_nxt;
        sck <= ~sck;
      end
      if (accept) begin
        cs_n <= sel_ok ? (l_cs_off ^ (l_cs_one << cs_sel)) : l_cs_off;
        // CPHA=0 must present the first bit before the first sck edge.
        if (p_cpha == 0) begin
          mosi  <= first_bit(data);
          tx_sr <= shift_out(data);
        end else begin
          tx_sr <= data;
        end
      end
      if (do_drive) begin
        mosi  <= first_bit(tx_sr);
        tx_sr <= shift_out(tx_sr);
      end
      if (do_sample) rx_sr <= shift_in(rx_sr, miso);
      if (finish) begin
        cs_n    <= l_cs_off;
        mosi    <= 1'b0;
        rx_data <= rx_sr;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_mc.sv
// tb/tb_spi_master_mc.sv - directed scoreboard bench over five spi_master_mc configurations
module tb_spi_master_mc;
  localparam int n_dut = 5;
  localparam int l_lat = (4 / 2) * (2 * 8 + 2) + 1;

  logic clk = 1'b0;
  logic a_rst = 1'b0;
  always #5 clk = ~clk;

  logic       valid_v[n_dut];
  logic [7:0] data;
  logic [1:0] cs_sel;
  logic       ready_v[n_dut], rx_valid_v[n_dut], cs_err_v[n_dut];
  logic       sck_v[n_dut], mosi_v[n_dut], miso_v[n_dut];
  logic [7:0] rx_data_v[n_dut];
  logic [2:0] cs_n_v[n_dut];

  logic [7:0] sl_tx[n_dut], cap[n_dut];
  logic       miso_r[n_dut], sck_p[n_dut], mosi_p[n_dut];
  int         unstable[n_dut], tog_cnt[n_dut], rise_cnt[n_dut], rx_cnt[n_dut], err_cnt[n_dut];
  int         cs_act[n_dut*3];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic [7:0] exp_q[$];
  int s_tog, s_rise, s_rx, s_err, s_unst;
  int s_cs[3];

  // 0: mode0 loopback, 1..3: modes 1..3 against slave, 4: mode0 LSB-first loopback
  function automatic logic cpol_of(input int i);
    return (i == 2 || i == 3);
  endfunction
  function automatic logic cpha_of(input int i);
    return (i == 1 || i == 3);
  endfunction

  for (genvar g = 0; g < n_dut; g++) begin : g_dut
    spi_master_mc #(
      .p_data_width(8), .p_clk_div(4), .p_cs_num(3), .p_cs_polar(1),
      .p_cpol((g == 2 || g == 3) ? 1 : 0),
      .p_cpha((g == 1 || g == 3) ? 1 : 0),
      .p_lsb_first((g == 4) ? 1 : 0)
    ) u_dut (
      .clk(clk), .a_rst(a_rst), .valid(valid_v[g]), .data(data), .cs_sel(cs_sel),
      .ready(ready_v[g]), .rx_data(rx_data_v[g]), .rx_valid(rx_valid_v[g]),
      .cs_err(cs_err_v[g]), .sck(sck_v[g]), .cs_n(cs_n_v[g]), .mosi(mosi_v[g]),
      .miso(miso_v[g])
    );
    assign miso_v[g] = (g == 0 || g == 4) ? mosi_v[g] :
                       ((g == 1 || g == 3) ? miso_r[g] : sl_tx[g][7]);
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Activity counters plus an MSB-first slave returning 0x3C and capturing mosi.
  always @(negedge clk) begin
    for (int i = 0; i < n_dut; i++) begin
      sck_p[i]  <= sck_v[i];
      mosi_p[i] <= mosi_v[i];
      if (sck_v[i] != sck_p[i]) begin
        tog_cnt[i] <= tog_cnt[i] + 1;
        if (sck_v[i]) rise_cnt[i] <= rise_cnt[i] + 1;
      end
      if (rx_valid_v[i]) rx_cnt[i] <= rx_cnt[i] + 1;
      if (cs_err_v[i])   err_cnt[i] <= err_cnt[i] + 1;
      for (int c = 0; c < 3; c++)
        if (!cs_n_v[i][c]) cs_act[i*3+c] <= cs_act[i*3+c] + 1;
      if (cs_n_v[i] == 3'b111) begin
        sl_tx[i]  <= 8'h3C;
        miso_r[i] <= 1'b0;
      end else if (sck_v[i] != sck_p[i]) begin
        if ((sck_p[i] == cpol_of(i)) != cpha_of(i)) begin
          cap[i] <= {cap[i][6:0], mosi_v[i]};
          if (mosi_v[i] != mosi_p[i]) unstable[i] <= unstable[i] + 1;
        end else begin
          if (cpha_of(i)) miso_r[i] <= sl_tx[i][7];
          sl_tx[i] <= sl_tx[i] << 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    assert (obs === want) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic snap(input int i);
    s_tog = tog_cnt[i]; s_rise = rise_cnt[i]; s_rx = rx_cnt[i];
    s_err = err_cnt[i]; s_unst = unstable[i];
    for (int c = 0; c < 3; c++) s_cs[c] = cs_act[i*3+c];
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input logic [7:0] d, input logic [1:0] sel, input logic [7:0] want);
    @(negedge clk);
    chk("send_ready", 32'(ready_v[i]), 1);
    valid_v[i] = 1'b1; data = d; cs_sel = sel;
    acc_cyc = cyc;
    exp_q.push_back(want);
    @(negedge clk);
    valid_v[i] = 1'b0; data = 8'h00;
  endtask

  task automatic check_rx(input int i, input string tag);
    int lat;
    logic [7:0] want;
    lat = -1;
    for (int k = 0; k < 200 && lat < 0; k++) begin
      @(negedge clk);
      if (rx_valid_v[i]) lat = cyc - acc_cyc;
    end
    chk({tag, "_latency"}, 32'(lat), l_lat);
    want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    chk({tag, "_rx_data"}, 32'(rx_data_v[i]), 32'(want));
  endtask

  initial begin
    for (int i = 0; i < n_dut; i++) valid_v[i] = 1'b0;
    data = 8'h00; cs_sel = 2'd0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < n_dut; i++) begin
      chk("rst_ready", 32'(ready_v[i]), 1);
      chk("rst_sck", 32'(sck_v[i]), 32'(cpol_of(i)));
      chk("rst_cs_n", 32'(cs_n_v[i]), 3'b111);
      chk("rst_mosi", 32'(mosi_v[i]), 0);
      chk("rst_rx_valid", 32'(rx_valid_v[i]), 0);
      chk("rst_cs_err", 32'(cs_err_v[i]), 0);
      chk("rst_rx_data", 32'(rx_data_v[i]), 0);
    end
    #2 a_rst = 1'b1;

    // mode 0 loopback, 0xA5 on cs 0
    snap(0);
    send(0, 8'hA5, 2'd0, 8'hA5);
    check_rx(0, "m0");
    settle();
    chk("m0_cs0_active", 32'(cs_act[0] - s_cs[0]), 36);
    chk("m0_cs1_active", 32'(cs_act[1] - s_cs[1]), 0);
    chk("m0_sck_rises", 32'(rise_cnt[0] - s_rise), 8);
    chk("m0_rx_pulses", 32'(rx_cnt[0] - s_rx), 1);
    chk("m0_rx_valid_low", 32'(rx_valid_v[0]), 0);
    chk("m0_sck_idle", 32'(sck_v[0]), 0);

    // modes 1..3 against the slave model, 0xC3 on cs 2
    for (int i = 1; i <= 3; i++) begin
      snap(i);
      send(i, 8'hC3, 2'd2, 8'h3C);
      check_rx(i, "mode");
      settle();
      chk("mode_slave_got", 32'(cap[i]), 8'hC3);
      chk("mode_mosi_stable", 32'(unstable[i] - s_unst), 0);
      chk("mode_sck_toggles", 32'(tog_cnt[i] - s_tog), 16);
      chk("mode_sck_idle", 32'(sck_v[i]), 32'(cpol_of(i)));
      chk("mode_cs2_active", 32'(cs_act[i*3+2] - s_cs[2]), 36);
    end

    // LSB first, 0x01 loopback
    snap(4);
    send(4, 8'h01, 2'd0, 8'h01);
    check_rx(4, "lsb");
    settle();
    chk("lsb_mosi_order", 32'(cap[4]), 8'h80);
    chk("lsb_mosi_stable", 32'(unstable[4] - s_unst), 0);

    // back-to-back on cs 1 with valid held high
    snap(0);
    @(negedge clk);
    valid_v[0] = 1'b1; data = 8'h11; cs_sel = 2'd1;
    acc_cyc = cyc;
    exp_q.push_back(8'h11);
    @(negedge clk);
    data = 8'h22;
    chk("b2b_busy_ready", 32'(ready_v[0]), 0);
    check_rx(0, "b2b_first");
    chk("b2b_ready_in_rx_cycle", 32'(ready_v[0]), 1);
    chk("b2b_cs1_gap", 32'(cs_n_v[0][1]), 1);
    acc_cyc = cyc;
    exp_q.push_back(8'h22);
    @(negedge clk);
    valid_v[0] = 1'b0;
    chk("b2b_cs1_reassert", 32'(cs_n_v[0][1]), 0);
    check_rx(0, "b2b_second");
    settle();
    chk("b2b_cs1_active", 32'(cs_act[1] - s_cs[1]), 72);

    // out-of-range chip select
    snap(0);
    send(0, 8'h96, 2'd3, 8'h96);
    chk("oor_cs_err", 32'(cs_err_v[0]), 1);
    chk("oor_cs_n", 32'(cs_n_v[0]), 3'b111);
    check_rx(0, "oor");
    settle();
    chk("oor_err_pulses", 32'(err_cnt[0] - s_err), 1);
    chk("oor_cs_active", 32'((cs_act[0] - s_cs[0]) + (cs_act[1] - s_cs[1]) + (cs_act[2] - s_cs[2])), 0);
    chk("oor_sck_toggles", 32'(tog_cnt[0] - s_tog), 16);
    chk("oor_rx_pulses", 32'(rx_cnt[0] - s_rx), 1);

    // reset in the middle of the 4th bit
    snap(0);
    send(0, 8'hF0, 2'd0, 8'hF0);
    repeat (14) @(negedge clk);
    #2 a_rst = 1'b0;
    #1;
    chk("mid_rst_sck", 32'(sck_v[0]), 0);
    chk("mid_rst_cs_n", 32'(cs_n_v[0]), 3'b111);
    chk("mid_rst_ready", 32'(ready_v[0]), 1);
    chk("mid_rst_mosi", 32'(mosi_v[0]), 0);
    chk("mid_rst_rx_data", 32'(rx_data_v[0]), 0);
    exp_q.delete();
    @(negedge clk);
    #2 a_rst = 1'b1;
    repeat (60) @(negedge clk);
    settle();
    chk("mid_rst_no_rx", 32'(rx_cnt[0] - s_rx), 0);
    send(0, 8'h5A, 2'd0, 8'h5A);
    check_rx(0, "post_rst");

    settle();
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
